// File: rtl/skut_frame_serializer.sv
// -----------------------------------------------------------------------------
// skut_frame_serializer
//
// Downstream stage of the SKUT frame former. The former writes one telemetry
// frame (FRAME_LEN bytes) per 8 kHz period into one half of a ping-pong RAM.
// On each frame boundary the banks swap, and the frame that has just been
// completed is streamed to the serial line DAC, MSB first. Each byte gets its
// own chip-select burst. Output always lags input by exactly one frame, and a
// frame is never read while it is being written.
//
// Ports
//   iClk      : system clock, all logic on the rising edge
//   reset     : asynchronous active-high reset, clears all state immediately
//   iData     : frame byte from the former
//   iAddr     : frame byte address (slot index) from the former
//   iWrEn     : write strobe, level; every high cycle writes iData to iAddr
//   i8KHz     : frame strobe, asynchronous to iClk; a rising edge marks a
//               frame boundary
//   oSclk     : serial clock to the DAC
//   oSdo      : serial data, changes only while oSclk is low
//   oCs_n     : active-low chip select, one burst per byte
//   oBusy     : high while a frame is being streamed
//   oOverrun  : one-cycle pulse when a frame boundary arrives while busy
//   oByteIdx  : address of the byte currently being streamed
// -----------------------------------------------------------------------------
module skut_frame_serializer #(
  parameter int         FRAME_LEN = 80,
  parameter int         CLK_DIV   = 4,
  parameter logic [7:0] IDLE_CODE = 8'd124
) (
  input  logic       iClk,
  input  logic       reset,
  input  logic [7:0] iData,
  input  logic [6:0] iAddr,
  input  logic       iWrEn,
  input  logic       i8KHz,
  output logic       oSclk,
  output logic       oSdo,
  output logic       oCs_n,
  output logic       oBusy,
  output logic       oOverrun,
  output logic [6:0] oByteIdx
);

  // Counter wide enough for both the 2-cycle LOAD and CLK_DIV-cycle phases.
  localparam int              CNT_W    = $clog2(CLK_DIV + 2) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(1);
  localparam logic [6:0]      LAST_IDX = 7'(FRAME_LEN - 1);
  localparam logic [7:0]      LEN_8    = 8'(FRAME_LEN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic             sync1_q, sync2_q, sync3_q;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [1:0]       valid_q, valid_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;   // 0: oSclk low half, 1: high half
  logic [2:0]       bit_q, bit_d;       // bits already sent in this byte
  logic [7:0]       shreg_q, shreg_d;   // bit 7 is the bit on the line
  logic             sclk_q, sclk_d;
  logic             sdo_q, sdo_d;
  logic             cs_n_q, cs_n_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic [6:0]       idx_q, idx_d;

  // ---------------------------------------------------------------------------
  // Ping-pong frame RAM: bank in the top address bit, slot in the low 7 bits.
  // Read data is registered, which is why LOAD lasts two cycles.
  // ---------------------------------------------------------------------------
  logic [7:0] ram_mem [0:255];
  logic [7:0] ram_rd_q;
  logic       wr_ok;
  logic [7:0] ram_waddr;
  logic [7:0] ram_raddr;
  logic       frame_edge;

  // Out-of-range slot addresses are dropped entirely: no RAM write and no
  // effect on the bank-valid flag.
  assign wr_ok      = iWrEn && ({1'b0, iAddr} < LEN_8);
  assign ram_waddr  = {wr_bank_q, iAddr};
  assign ram_raddr  = {rd_bank_q, idx_q};
  assign frame_edge = sync2_q & ~sync3_q;

  always_ff @(posedge iClk) begin
    if (wr_ok) begin
      ram_mem[ram_waddr] <= iData;
    end
    ram_rd_q <= ram_raddr;
    ram_rd_q <= ram_mem[ram_raddr];
  end

  // ---------------------------------------------------------------------------
  // Bank-valid flags. A bank becomes valid on its first in-range write and is
  // cleared at the boundary that makes it the write bank again, so a frame
  // period with no writes streams IDLE_CODE. The clear only ever targets the
  // bank that is not currently being written, so it never races a set.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_valid
      localparam logic BANK = 1'(gi);
      assign valid_d[gi] = (frame_edge && (wr_bank_q != BANK)) ? 1'b0 :
                           (wr_ok && (wr_bank_q == BANK))      ? 1'b1 :
                                                                 valid_q[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    overrun_d = 1'b0;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;

    if (frame_edge) begin
      // A boundary always wins: swap banks and restart at slot 0, abandoning
      // whatever byte was in flight.
      rd_bank_d = wr_bank_q;
      wr_bank_d = ~wr_bank_q;
      overrun_d = busy_q;
      state_d   = ST_LOAD;
      cnt_d     = '0;
      phase_d   = 1'b0;
      bit_d     = 3'd0;
      idx_d     = 7'd0;
      busy_d    = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
        end

        ST_LOAD: begin
          // Cycle 0 presents the address, cycle 1 sees the registered data.
          if (cnt_q == LOAD_LAST) begin
            shreg_d = valid_q[rd_bank_q] ? ram_rd_q : IDLE_CODE;
            state_d = ST_SHIFT;
            cnt_d   = '0;
            phase_d = 1'b0;
            bit_d   = 3'd0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_SHIFT: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (!phase_q) begin
              phase_d = 1'b1;
            end else if (bit_q == 3'd7) begin
              phase_d = 1'b0;
              state_d = ST_GAP;
            end else begin
              // Next bit starts with oSclk low; shifting here moves the new
              // bit onto oSdo at the falling edge.
              phase_d = 1'b0;
              bit_d   = bit_q + 3'd1;
              shreg_d = {shreg_q[6:0], 1'b0};
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_GAP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (idx_q == LAST_IDX) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              idx_d   = 7'd0;
            end else begin
              state_d = ST_LOAD;
              idx_d   = idx_q + 7'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Line outputs are derived from the next state so they are registered
    // alongside it and never glitch.
    sclk_d = (state_d == ST_SHIFT) && phase_d;
    cs_n_d = (state_d != ST_SHIFT);
    sdo_d  = (state_d == ST_SHIFT) ? shreg_d[7] : sdo_q;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      valid_q   <= 2'b00;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      phase_q   <= 1'b0;
      bit_q     <= 3'd0;
      shreg_q   <= 8'd0;
      sclk_q    <= 1'b0;
      sdo_q     <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      idx_q     <= 7'd0;
    end else begin
      // Two-flop synchroniser for the asynchronous frame strobe, plus one
      // more stage for rising-edge detection.
      sync1_q   <= i8KHz;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      valid_q   <= valid_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      sclk_q    <= sclk_d;
      sdo_q     <= sdo_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      idx_q     <= idx_d;
    end
  end

  assign oSclk    = sclk_q;
  assign oSdo     = sdo_q;
  assign oCs_n    = cs_n_q;
  assign oBusy    = busy_q;
  assign oOverrun = overrun_q;
  assign oByteIdx = idx_q;

endmodule
